snake_input_ctrl: RTL



---
 rtl/snake_input_ctrl_if.sv | 31 +++
 rtl/snake_input_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/snake_input_ctrl_if.sv
// Bundles the button/tick inputs and the direction/queue-status outputs of
// snake_input_ctrl.
//   btn        raw push buttons (bit0 up, bit1 right, bit2 down, bit3 left)
//   tick       one-cycle pulse at each snake step
//   control    current direction (0 up, 1 right, 2 down, 3 left)
//   pending    turn queue non-empty
//   fifo_count number of queued turns
//   overflow   sticky, an accepted turn was lost to a full queue
// master: the side that drives buttons/tick; slave: the controller.
interface snake_input_ctrl_if #(
   parameter int FIFO_DEPTH = 2
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]       btn;
   logic             tick;
   logic [1:0]       control;
   logic             pending;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;

   modport master (
      output btn, tick,
      input  control, pending, fifo_count, overflow
   );

   modport slave (
      input  btn, tick,
      output control, pending, fifo_count, overflow
   );
endinterface

// File: rtl/snake_input_ctrl.sv
// Snake direction controller: synchronises and debounces four buttons,
// turns debounced rising edges into turn requests, filters redundant and
// reversing turns, and queues accepted turns so one is applied per tick.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  snake_input_ctrl_if.slave (btn, tick in; control, pending,
//        fifo_count, overflow out)
module snake_input_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter int         FIFO_DEPTH      = 2,
   parameter logic [1:0] INIT_DIR        = 2'd1
) (
   input logic               clk,
   input logic               rst,
   snake_input_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

   logic [3:0]    sync_a;
   logic [3:0]    sync_b;
   logic [3:0]    deb;
   logic [3:0]    deb_prev;
   logic [DW-1:0] deb_cnt [4];

   logic [1:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [1:0]    control_r;
   logic          overflow_r;

   logic [3:0]    press;
   logic [1:0]    cand;
   logic [1:0]    ref_dir;
   logic [PW-1:0] tail_ptr;
   logic          accepted;
   logic          pop;
   logic          push;

   always_comb begin
      press    = deb & ~deb_prev;
      cand     = 2'd3;
      if (press[0])      cand = 2'd0;
      else if (press[1]) cand = 2'd1;
      else if (press[2]) cand = 2'd2;
      tail_ptr = wr_ptr - PW'(1);
      // Compare against the last queued turn so a queued pair cannot reverse.
      ref_dir  = (count != '0) ? fifo_mem[tail_ptr] : control_r;
      accepted = (press != 4'd0) && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
      pop      = bus.tick && (count != '0);
      // A simultaneous pop frees a slot, so a full queue still accepts.
      push     = accepted && ((count < FULL) || pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a     <= '0;
         sync_b     <= '0;
         deb        <= '0;
         deb_prev   <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         control_r  <= INIT_DIR;
         overflow_r <= 1'b0;
      end else begin
         sync_a   <= bus.btn;
         sync_b   <= sync_a;
         deb_prev <= deb;
         for (int i = 0; i < 4; i++) begin
            if (sync_b[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= ~deb[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
         if (pop) begin
            control_r <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + PW'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (accepted && !push)
            overflow_r <= 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // When full with push and pop together, wr_ptr equals rd_ptr; the pop
   // above reads the old entry before this write lands.
   always_ff @(posedge clk) begin
      if (push && !rst)
         fifo_mem[wr_ptr] <= cand;
   end

   assign bus.control    = control_r;
   assign bus.fifo_count = count;
   assign bus.pending    = (count != '0);
   assign bus.overflow   = overflow_r;
endmodule
